// File: rtl/uart_frame_sequencer.sv
// Frame sequencer for a shared UART transmitter: snapshots DEVICES sensor bytes and
// sends HEADER, data bytes (device 0 first), checksum; supervises each byte with a timeout.
module uart_frame_sequencer #(
  parameter int         DEVICES      = 2,
  parameter logic [7:0] HEADER       = 8'hAA,
  parameter int         CLKS_PER_BIT = 5208,
  parameter int         GAP_CLKS     = 10000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 auto_mode,
  input  logic [DEVICES*8-1:0] data_in,
  input  logic                 tx_done,
  output logic [7:0]           tx_data,
  output logic                 tx_enable,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 error
);

  localparam int TIMEOUT = 12 * CLKS_PER_BIT;
  localparam int IW      = $clog2(DEVICES + 2);
  localparam int TW      = $clog2(TIMEOUT + 1);
  localparam int GW      = $clog2(GAP_CLKS + 2);

  // idx is the byte currently in flight: 0 header, 1..DEVICES data, DEVICES+1 checksum
  localparam logic [IW-1:0] LAST_IDX = IW'(DEVICES + 1);
  localparam logic [IW-1:0] CSUM_PREV = IW'(DEVICES);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

  state_t               state, state_d;
  logic [DEVICES*8-1:0] snap, snap_d;
  logic [IW-1:0]        idx, idx_d;
  logic [7:0]           sum, sum_d, tx_data_d, data_byte;
  logic [TW-1:0]        tcnt, tcnt_d;
  logic [GW-1:0]        gcnt, gcnt_d;
  logic                 tx_enable_d, busy_d, frame_done_d, error_d;

  always_comb begin
    data_byte = '0;
    for (int i = 0; i < DEVICES; i++) begin
      if (idx == IW'(i)) data_byte = snap[i*8 +: 8];
    end
  end

  // Transmitter handshake: a one-cycle tx_enable hands tx_data over (tx_data stays put
  // until the next load); the transmitter answers with a one-cycle tx_done, honoured only in WAIT.
  always_comb begin
    state_d      = state;
    snap_d       = snap;
    idx_d        = idx;
    sum_d        = sum;
    tx_data_d    = tx_data;
    tcnt_d       = tcnt;
    gcnt_d       = gcnt;
    tx_enable_d  = 1'b0;
    frame_done_d = 1'b0;
    error_d      = error;
    busy_d       = busy;
    case (state)
      IDLE: begin
        if (start | auto_mode) begin
          snap_d      = data_in;
          error_d     = 1'b0;
          idx_d       = '0;
          sum_d       = HEADER;
          tx_data_d   = HEADER;
          tx_enable_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        tcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          if (idx == LAST_IDX) begin
            frame_done_d = 1'b1;
            gcnt_d       = '0;
            if (GAP_CLKS == 0) begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              state_d = GAP;
            end
          end else begin
            idx_d       = idx + 1'b1;
            tx_enable_d = 1'b1;
            state_d     = SEND;
            if (idx == CSUM_PREV) begin
              tx_data_d = sum;
            end else begin
              tx_data_d = data_byte;
              sum_d     = sum + data_byte;
            end
          end
        end else if (tcnt == TO_LAST) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt + 1'b1;
        end
      end
      GAP: begin
        // The frame_done cycle is the first of GAP_CLKS+1 cycles spent here.
        if (gcnt == GAP_LAST) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gcnt_d = gcnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      snap       <= '0;
      idx        <= '0;
      sum        <= '0;
      tx_data    <= '0;
      tcnt       <= '0;
      gcnt       <= '0;
      tx_enable  <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      snap       <= snap_d;
      idx        <= idx_d;
      sum        <= sum_d;
      tx_data    <= tx_data_d;
      tcnt       <= tcnt_d;
      gcnt       <= gcnt_d;
      tx_enable  <= tx_enable_d;
      frame_done <= frame_done_d;
      error      <= error_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Directed bench for uart_frame_sequencer with a transmitter model that answers
// each tx_enable with tx_done a fixed number of cycles later.
module tb_uart_frame_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        auto_mode;
  logic [15:0] data_in;
  logic        tx_done;
  logic [7:0]  tx_data;
  logic        tx_enable;
  logic        busy;
  logic        frame_done;
  logic        error;

  uart_frame_sequencer #(
    .DEVICES(2), .HEADER(8'hAA), .CLKS_PER_BIT(4), .GAP_CLKS(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .auto_mode(auto_mode),
    .data_in(data_in), .tx_done(tx_done), .tx_data(tx_data),
    .tx_enable(tx_enable), .busy(busy), .frame_done(frame_done), .error(error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // transmitter model and monitor (samples on the falling edge)
  logic       tx_model_en = 1'b1;
  int         tx_delay    = 20;
  int         en_cnt      = 0;
  int         fd_cnt      = 0;
  logic [7:0] cap_q[$];

  initial begin
    int cd;
    cd = 0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0 && tx_model_en) tx_done = 1'b1;
      end
      if (tx_enable === 1'b1) begin
        cap_q.push_back(tx_data);
        en_cnt++;
        cd = tx_delay;
      end
      if (frame_done === 1'b1) fd_cnt++;
    end
  end

  // scoreboard
  logic [7:0] exp_q[$];
  int n_cmp  = 0;
  int n_bad  = 0;
  int rd_ptr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag);
    int n;
    n = exp_q.size();
    check({tag, "_len"}, cap_q.size() - rd_ptr, n);
    for (int i = 0; i < n; i++) begin
      if (rd_ptr < cap_q.size()) begin
        check($sformatf("%s_byte%0d", tag, i), cap_q[rd_ptr], exp_q[i]);
        rd_ptr++;
      end
    end
    exp_q.delete();
    rd_ptr = cap_q.size();
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_fd(input string tag, input int budget);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, frame_done, 1'b1);
  endtask

  int en_base;
  int fd_base;

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    auto_mode = 1'b0;
    data_in   = 16'h0000;
    tick(3);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_enable", tx_enable, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_error", error, 1'b0);
    rst_n = 1'b1;
    tick(2);

    // basic frame; data_in changes right after acceptance
    en_base = en_cnt; fd_base = fd_cnt;
    data_in = 16'h3412;
    pulse_start();
    check("f1_first_en", tx_enable, 1'b1);
    check("f1_first_data", tx_data, 8'hAA);
    check("f1_busy", busy, 1'b1);
    data_in = 16'hFFFF;
    exp_q = '{8'hAA, 8'h12, 8'h34, 8'hF0};
    wait_fd("f1_frame_done", 200);
    tick(1);
    check("f1_fd_pulse", frame_done, 1'b0);
    tick(4);
    check("f1_gap_busy", busy, 1'b1);
    tick(1);
    check("f1_idle_busy", busy, 1'b0);
    check_frame("f1");
    check("f1_en_count", en_cnt - en_base, 4);
    check("f1_fd_count", fd_cnt - fd_base, 1);

    // checksum wrap; start pulses in WAIT and in GAP are ignored
    en_base = en_cnt; fd_base = fd_cnt;
    pulse_start();
    check("f2_first_data", tx_data, 8'hAA);
    tick(5);
    pulse_start();
    exp_q = '{8'hAA, 8'hFF, 8'hFF, 8'hA8};
    wait_fd("f2_frame_done", 200);
    tick(2);
    pulse_start();
    tick(30);
    check("f2_idle_busy", busy, 1'b0);
    check("f2_en_count", en_cnt - en_base, 4);
    check("f2_fd_count", fd_cnt - fd_base, 1);
    check_frame("f2");

    // auto mode: next header 7 cycles after frame_done
    en_base = en_cnt;
    data_in = 16'h0102;
    auto_mode = 1'b1;
    tick(1);
    check("auto_first_en", tx_enable, 1'b1);
    exp_q = '{8'hAA, 8'h02, 8'h01, 8'hAD, 8'hAA, 8'h02, 8'h01, 8'hAD};
    wait_fd("auto_fd1", 200);
    tick(6);
    check("auto_c6_en", tx_enable, 1'b0);
    check("auto_c6_busy", busy, 1'b0);
    tick(1);
    check("auto_c7_en", tx_enable, 1'b1);
    check("auto_c7_data", tx_data, 8'hAA);
    auto_mode = 1'b0;
    wait_fd("auto_fd2", 200);
    tick(20);
    check("auto_idle_busy", busy, 1'b0);
    check("auto_en_count", en_cnt - en_base, 8);
    check_frame("auto");

    // byte timeout after the second byte (48 WAIT cycles)
    fd_base = fd_cnt;
    data_in = 16'h3412;
    pulse_start();
    tick(21);
    check("to_second_en", tx_enable, 1'b1);
    check("to_second_data", tx_data, 8'h12);
    tx_model_en = 1'b0;
    tick(48);
    check("to_last_wait_busy", busy, 1'b1);
    check("to_last_wait_err", error, 1'b0);
    tick(1);
    check("to_idle_busy", busy, 1'b0);
    check("to_error", error, 1'b1);
    check("to_no_fd", fd_cnt - fd_base, 0);
    exp_q = '{8'hAA, 8'h12};
    check_frame("to");
    tx_model_en = 1'b1;
    tick(5);
    check("to_error_sticky", error, 1'b1);
    pulse_start();
    check("to_err_clear", error, 1'b0);
    exp_q = '{8'hAA, 8'h12, 8'h34, 8'hF0};
    wait_fd("to_next_fd", 200);
    tick(10);
    check_frame("to_next");

    // asynchronous reset mid-WAIT, stray tx_done afterwards
    pulse_start();
    tick(5);
    check("ar_pre_data", tx_data, 8'hAA);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_tx_data", tx_data, 8'h00);
    check("ar_busy", busy, 1'b0);
    check("ar_tx_enable", tx_enable, 1'b0);
    check("ar_error", error, 1'b0);
    tick(2);
    rst_n = 1'b1;
    en_base = en_cnt;
    tick(20);
    check("ar_stray_busy", busy, 1'b0);
    check("ar_stray_en", en_cnt - en_base, 0);
    exp_q = '{8'hAA};
    check_frame("ar_pre");
    data_in = 16'h5A01;
    pulse_start();
    exp_q = '{8'hAA, 8'h01, 8'h5A, 8'h05};
    wait_fd("ar_fresh_fd", 200);
    tick(10);
    check_frame("ar_fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
